// File: rtl/axis_arbiter_rr.sv
// Packet-granular round-robin arbiter merging NSLAVES AXI-Stream inputs onto one output.
// A granted slave owns the output until its last beat (or for one beat when HAS_LAST=0).
module axis_arbiter_rr #(
    parameter int NSLAVES    = 2,
    parameter int DATA_WIDTH = 64,
    parameter bit HAS_DEST   = 1'b0,
    parameter bit HAS_ID     = 1'b0,
    parameter bit HAS_LAST   = 1'b0,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NSLAVES-1:0]               s_valid,
    output logic [NSLAVES-1:0]               s_ready,
    input  logic [NSLAVES*DATA_WIDTH-1:0]    s_data,
    input  logic [NSLAVES*DEST_WIDTH-1:0]    s_dest,
    input  logic [NSLAVES*ID_WIDTH-1:0]      s_id,
    input  logic [NSLAVES-1:0]               s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic                             m_last
);

    localparam int GW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    // Disabled sideband fields leave some inputs without a reader in some configurations.
    logic unused_inputs;
    assign unused_inputs = ^{aclk, aresetn, s_dest, s_id, s_last};

    generate
        if (NSLAVES == 1) begin : g_wire
            assign m_valid    = s_valid[0];
            assign s_ready[0] = m_ready;
            assign m_data     = s_data;
            assign m_dest     = HAS_DEST ? s_dest : '0;
            assign m_id       = HAS_ID ? s_id : '0;
            assign m_last     = HAS_LAST ? s_last[0] : 1'b0;
        end else begin : g_arb
            typedef enum logic {
                IDLE,
                TRANSACTION
            } state_t;

            state_t          state, state_next;
            logic [GW-1:0]   grant, grant_next;
            logic [GW-1:0]   ptr, ptr_next;
            logic            sel_last;
            logic            found;
            int              idx;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    state <= IDLE;
                    grant <= '0;
                    ptr   <= '0;
                end else begin
                    state <= state_next;
                    grant <= grant_next;
                    ptr   <= ptr_next;
                end
            end

            // Sideband fields follow grant in every state; only valid/ready are gated.
            assign m_data   = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            assign m_dest   = HAS_DEST ? s_dest[int'(grant)*DEST_WIDTH +: DEST_WIDTH] : '0;
            assign m_id     = HAS_ID ? s_id[int'(grant)*ID_WIDTH +: ID_WIDTH] : '0;
            assign sel_last = s_last[grant];
            assign m_last   = HAS_LAST ? sel_last : 1'b0;

            always_comb begin
                state_next = state;
                grant_next = grant;
                ptr_next   = ptr;
                m_valid    = 1'b0;
                s_ready    = '0;
                found      = 1'b0;
                idx        = 0;
                case (state)
                    IDLE: begin
                        if (|s_valid) begin
                            state_next = TRANSACTION;
                            // Search upward from ptr, wrapping modulo NSLAVES.
                            for (int k = 0; k < NSLAVES; k++) begin
                                idx = int'(ptr) + k;
                                if (idx >= NSLAVES) idx = idx - NSLAVES;
                                if (!found && s_valid[idx]) begin
                                    found      = 1'b1;
                                    grant_next = GW'(idx);
                                end
                            end
                        end
                    end
                    TRANSACTION: begin
                        m_valid        = s_valid[grant];
                        s_ready[grant] = m_ready;
                        if (m_valid && m_ready && (!HAS_LAST || sel_last)) begin
                            state_next = IDLE;
                            ptr_next   = (grant == GW'(NSLAVES - 1)) ? '0 : grant + 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    endgenerate

endmodule

// File: tb/tb_axis_arbiter_rr.sv
// Bench for axis_arbiter_rr: two configurations checked every cycle against a
// packet-level round-robin model, plus directed scenarios with literal expectations.
module tb_axis_arbiter_rr;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    // Config A: 3 slaves, last/dest/id enabled.
    logic [2:0]  s_valid_a, s_ready_a, s_last_a;
    logic [47:0] s_data_a;
    logic [8:0]  s_dest_a;
    logic [5:0]  s_id_a;
    logic        m_valid_a, m_ready_a, m_last_a;
    logic [15:0] m_data_a;
    logic [2:0]  m_dest_a;
    logic [1:0]  m_id_a;

    // Config B: 4 slaves, every beat is a packet, sideband disabled.
    logic [3:0]  s_valid_b, s_ready_b, s_last_b;
    logic [63:0] s_data_b;
    logic [3:0]  s_dest_b, s_id_b;
    logic        m_valid_b, m_ready_b, m_last_b;
    logic [15:0] m_data_b;
    logic [0:0]  m_dest_b, m_id_b;

    axis_arbiter_rr #(.NSLAVES(3), .DATA_WIDTH(16), .HAS_DEST(1'b1), .HAS_ID(1'b1),
                      .HAS_LAST(1'b1), .ID_WIDTH(2), .DEST_WIDTH(3)) dut_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
        .s_dest(s_dest_a), .s_id(s_id_a), .s_last(s_last_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
        .m_dest(m_dest_a), .m_id(m_id_a), .m_last(m_last_a));

    axis_arbiter_rr #(.NSLAVES(4), .DATA_WIDTH(16), .HAS_DEST(1'b0), .HAS_ID(1'b0),
                      .HAS_LAST(1'b0), .ID_WIDTH(1), .DEST_WIDTH(1)) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .s_dest(s_dest_b), .s_id(s_id_b), .s_last(s_last_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
        .m_dest(m_dest_b), .m_id(m_id_b), .m_last(m_last_b));

    int n_chk = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: which slave owns the output, and who is next in line.
    bit busy[2]  = '{0, 0};
    int owner[2] = '{0, 0};
    int rr[2]    = '{0, 0};
    bit nbusy[2] = '{0, 0};
    int nowner[2] = '{0, 0};
    int nrr[2]   = '{0, 0};

    task automatic model_cycle(input int d, input int n, input bit hl,
                               input logic [3:0] v, input logic [3:0] l, input logic mr,
                               output bit emv, output logic [3:0] esr, output int src);
        bit found;
        emv = busy[d] && (v[owner[d]] == 1'b1);
        esr = (busy[d] && mr) ? (4'b0001 << owner[d]) : 4'b0000;
        src = owner[d];
        nbusy[d] = busy[d];
        nowner[d] = owner[d];
        nrr[d] = rr[d];
        found = 1'b0;
        if (!aresetn) begin
            nbusy[d] = 1'b0;
            nowner[d] = 0;
            nrr[d] = 0;
        end else if (!busy[d]) begin
            for (int k = 0; k < n; k++) begin
                if (!found && v[(rr[d] + k) % n]) begin
                    found = 1'b1;
                    nowner[d] = (rr[d] + k) % n;
                    nbusy[d] = 1'b1;
                end
            end
        end else if (emv && mr && (!hl || l[owner[d]])) begin
            nbusy[d] = 1'b0;
            nrr[d] = (owner[d] + 1) % n;
        end
    endtask

    always @(posedge aclk or negedge aresetn) begin
        for (int d = 0; d < 2; d++) begin
            if (!aresetn) begin
                busy[d] <= 1'b0;
                owner[d] <= 0;
                rr[d] <= 0;
            end else begin
                busy[d] <= nbusy[d];
                owner[d] <= nowner[d];
                rr[d] <= nrr[d];
            end
        end
    end

    always @(negedge aclk) begin
        bit emv;
        logic [3:0] esr;
        int src;
        if (run_chk) begin
            model_cycle(0, 3, 1'b1, {1'b0, s_valid_a}, {1'b0, s_last_a}, m_ready_a, emv, esr, src);
            chk("a_m_valid", m_valid_a, emv);
            chk("a_s_ready", s_ready_a, esr[2:0]);
            chk("a_m_data", m_data_a, s_data_a[src*16 +: 16]);
            chk("a_m_last", m_last_a, s_last_a[src]);
            chk("a_m_id", m_id_a, s_id_a[src*2 +: 2]);
            chk("a_m_dest", m_dest_a, s_dest_a[src*3 +: 3]);
            model_cycle(1, 4, 1'b0, s_valid_b, s_last_b, m_ready_b, emv, esr, src);
            chk("b_m_valid", m_valid_b, emv);
            chk("b_s_ready", s_ready_b, esr);
            chk("b_m_data", m_data_b, s_data_b[src*16 +: 16]);
            chk("b_m_last", m_last_b, 1'b0);
            chk("b_m_id", m_id_b, 1'b0);
            chk("b_m_dest", m_dest_b, 1'b0);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [15:0] da(input int i, input int b);
        return 16'(32'hA000 + i * 256 + b);
    endfunction

    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        s_valid_a = '0; s_last_a = '0; s_data_a = '0; s_dest_a = '0; s_id_a = '0; m_ready_a = 1'b1;
        s_valid_b = '0; s_last_b = '0; s_dest_b = '0; s_id_b = '0; m_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) s_data_b[i*16 +: 16] = 16'(32'hB000 + i);
        for (int i = 0; i < 3; i++) s_data_a[i*16 +: 16] = da(i, 0);
        s_id_a = 6'b10_01_00;
        s_dest_a = 9'o654;

        // Reset with both requesting: outputs quiet.
        #1;
        aresetn = 1'b0;
        s_valid_a = 3'b111;
        run_chk = 1'b1;
        #1;
        chk("rst_m_valid", m_valid_a, 1'b0);
        chk("rst_s_ready", s_ready_a, 3'b000);
        repeat (2) tick();
        aresetn = 1'b1;
        s_valid_a = 3'b011;
        #1;
        chk("rst_bubble", m_valid_a, 1'b0);
        tick();
        chk("first_grant_valid", m_valid_a, 1'b1);
        chk("first_grant_src", m_data_a, da(0, 0));

        // Packet lock: slave 0 sends 4 beats while slave 1 waits.
        for (int b = 0; b < 4; b++) begin
            s_data_a[15:0] = da(0, b);
            s_last_a[0] = (b == 3);
            #1;
            chk("lock_data", m_data_a, da(0, b));
            chk("lock_s1_ready", s_ready_a[1], 1'b0);
            tick();
        end
        s_valid_a[0] = 1'b0;
        s_last_a = 3'b010;
        #1;
        chk("lock_bubble", m_valid_a, 1'b0);
        tick();
        chk("lock_next_valid", m_valid_a, 1'b1);
        chk("lock_next_src", m_data_a, da(1, 0));
        chk("lock_next_ready", s_ready_a, 3'b010);
        tick();

        // Backpressure: ptr is 2, slave 0 wins with slave 1 also requesting.
        s_valid_a = 3'b011;
        s_last_a = 3'b000;
        s_data_a[15:0] = da(0, 5);
        m_ready_a = 1'b0;
        tick();
        repeat (5) begin
            #1;
            chk("bp_valid", m_valid_a, 1'b1);
            chk("bp_data", m_data_a, da(0, 5));
            chk("bp_ready", s_ready_a, 3'b000);
            tick();
        end
        m_ready_a = 1'b1;
        s_last_a[0] = 1'b1;
        #1;
        chk("bp_release_ready", s_ready_a, 3'b001);
        tick();
        s_valid_a = 3'b100;
        s_last_a = 3'b000;
        s_data_a[47:32] = da(2, 0);

        // Mid-packet reset during beat 2 of slave 2's packet.
        tick();
        #1;
        chk("mpr_beat1", m_data_a, da(2, 0));
        tick();
        s_data_a[47:32] = da(2, 1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("mpr_m_valid", m_valid_a, 1'b0);
        chk("mpr_s_ready", s_ready_a, 3'b000);
        chk("mpr_grant0", m_data_a, da(0, 5));
        s_valid_a = 3'b101;
        s_data_a[15:0] = da(0, 7);
        tick();
        aresetn = 1'b1;
        #1;
        chk("mpr_bubble", m_valid_a, 1'b0);
        tick();
        chk("mpr_first_valid", m_valid_a, 1'b1);
        chk("mpr_first_src", m_data_a, da(0, 7));
        s_last_a[0] = 1'b1;
        tick();
        s_valid_a = 3'b000;
        s_last_a = 3'b000;

        // Pointer skip on 4 slaves: two grants to slave 1 leave ptr at 2.
        s_valid_b = 4'b0010;
        tick();
        #1;
        chk("skip_g1_src", m_data_b, 16'hB001);
        tick();
        #1;
        chk("skip_bubble", m_valid_b, 1'b0);
        tick();
        #1;
        chk("skip_g2_src", m_data_b, 16'hB001);
        tick();
        s_valid_b = 4'b1001;
        #1;
        chk("skip_idle", m_valid_b, 1'b0);
        tick();
        #1;
        chk("skip_winner", m_data_b, 16'hB003);
        chk("skip_winner_valid", m_valid_b, 1'b1);
        tick();

        // All four requesting: strict rotation, one beat every two cycles.
        s_valid_b = 4'b1111;
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_valid", m_valid_b, 1'b1);
            chk("rr_src", m_data_b, 16'(32'hB000 + exp_rr[k]));
            tick();
            #1;
            chk("rr_bubble", m_valid_b, 1'b0);
            tick();
        end
        s_valid_b = 4'b0000;

        // Random traffic on both configurations.
        repeat (3000) begin
            for (int i = 0; i < 3; i++) begin
                s_valid_a[i] = ($urandom_range(0, 99) < 60);
                s_last_a[i] = ($urandom_range(0, 99) < 30);
                s_data_a[i*16 +: 16] = 16'($urandom);
                s_id_a[i*2 +: 2] = 2'($urandom);
                s_dest_a[i*3 +: 3] = 3'($urandom);
            end
            for (int i = 0; i < 4; i++) begin
                s_valid_b[i] = ($urandom_range(0, 99) < 50);
                s_last_b[i] = 1'($urandom);
                s_data_b[i*16 +: 16] = 16'($urandom);
                s_id_b[i] = 1'($urandom);
                s_dest_b[i] = 1'($urandom);
            end
            m_ready_a = ($urandom_range(0, 99) < 70);
            m_ready_b = ($urandom_range(0, 99) < 70);
            tick();
        end

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
